// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control unit.
// States, opcodes, ALU codes and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    JAL,
    BEQ
  } state_t;

  typedef enum logic [1:0] {
    ADD,
    SUB,
    FUNCT
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode from the FSM's alu_op and the instruction fields.
// Subtract only for R-type with funct7[5] set; I-type addi stays add.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Combinational ALU function select
  always_comb begin
    alu_control = ALUC_ADD;
    unique case (alu_op)
      ADD: alu_control = ALUC_ADD;
      SUB: alu_control = ALUC_SUB;
      FUNCT: begin
        unique case (funct3)
          3'b000: alu_control = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010: alu_control = ALUC_SLT;
          3'b110: alu_control = ALUC_OR;
          3'b111: alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle datapath.
// Also decodes imm_src and counts retired instructions.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 reg_write,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] instr_retired
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  alu_op_t              alu_op;
  logic                 pc_update, branch;
  logic                 ir_w, mem_w, reg_w, ill;
  logic                 retire;

  // State and retired-count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next state and Moore decode of datapath controls
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    retire     = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ADD;
    unique case (state_q)
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_w       = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default: begin
            state_d = FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = FUNCT;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
        retire  = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = SUB;
        branch    = 1'b1;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Counter next value, wrapping naturally
  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + CNT_WIDTH'(1);
  end

  // Immediate format from opcode, valid in every state
  always_comb begin
    imm_src = IMM_I;
    unique case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Strobes are killed the moment reset rises, before the state flop settles
  assign pc_write   = ~reset & (pc_update | (branch & zero));
  assign ir_write   = ~reset & ir_w;
  assign mem_write  = ~reset & mem_w;
  assign reg_write  = ~reset & reg_w;
  assign illegal_op = ~reset & ill;

  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Each cycle checks the full control bundle against a hand-built pattern.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic        reg_write, illegal_op;
  logic [31:0] instr_retired;

  int compared = 0;
  int mismatched = 0;

  // {pcw,adr,mw,irw,res[1:0],srca[1:0],srcb[1:0],rw,ill}
  localparam logic [11:0] P_FETCH  = 12'b1_0_0_1_10_00_10_0_0;
  localparam logic [11:0] P_FSTALL = 12'b0_0_0_0_10_00_10_0_0;
  localparam logic [11:0] P_DEC    = 12'b0_0_0_0_00_01_01_0_0;
  localparam logic [11:0] P_DECILL = 12'b0_0_0_0_00_01_01_0_1;
  localparam logic [11:0] P_MEMADR = 12'b0_0_0_0_00_10_01_0_0;
  localparam logic [11:0] P_MEMRD  = 12'b0_1_0_0_00_00_00_0_0;
  localparam logic [11:0] P_MEMWB  = 12'b0_0_0_0_01_00_00_1_0;
  localparam logic [11:0] P_MEMWR  = 12'b0_1_1_0_00_00_00_0_0;
  localparam logic [11:0] P_EXECR  = 12'b0_0_0_0_00_10_00_0_0;
  localparam logic [11:0] P_EXECI  = 12'b0_0_0_0_00_10_01_0_0;
  localparam logic [11:0] P_ALUWB  = 12'b0_0_0_0_00_00_00_1_0;
  localparam logic [11:0] P_JAL    = 12'b1_0_0_0_00_01_10_0_0;
  localparam logic [11:0] P_BEQT   = 12'b1_0_0_0_00_10_00_0_0;
  localparam logic [11:0] P_BEQN   = 12'b0_0_0_0_00_10_00_0_0;

  logic [11:0] bundle;
  assign bundle = {pc_write, adr_src, mem_write, ir_write, result_src,
                   alu_src_a, alu_src_b, reg_write, illegal_op};

  multicycle_controller #(.CNT_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .reg_write     (reg_write),
    .illegal_op    (illegal_op),
    .instr_retired (instr_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [11:0] exp);
    #1;
    chk(tag, 32'(bundle), 32'(exp));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    op = 7'b0110011;
    funct3 = 3'b000;
    funct7b5 = 1'b1;
    zero = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_bundle", P_FSTALL);
    chk("rst_cnt", instr_retired, 32'd0);
    reset = 1'b0;

    // R-type sub
    cyc("r_fetch", P_FETCH);
    nxt(); cyc("r_dec", P_DEC);
    chk("r_dec_alu", 32'(alu_control), 32'd0);
    nxt(); cyc("r_execr", P_EXECR);
    chk("r_execr_alu", 32'(alu_control), 32'd1);
    nxt(); cyc("r_aluwb", P_ALUWB);
    nxt(); cyc("r_fetch2", P_FETCH);
    chk("r_cnt", instr_retired, 32'd1);

    // lw with two stall cycles in MEMREAD
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    cyc("lw_fetch", P_FETCH);
    chk("lw_imm", 32'(imm_src), 32'd0);
    nxt(); cyc("lw_dec", P_DEC);
    nxt(); cyc("lw_memadr", P_MEMADR);
    nxt(); mem_ready = 1'b0; cyc("lw_rd0", P_MEMRD);
    nxt(); cyc("lw_rd1", P_MEMRD);
    nxt(); mem_ready = 1'b1; cyc("lw_rd2", P_MEMRD);
    nxt(); cyc("lw_memwb", P_MEMWB);
    nxt(); cyc("lw_fetch2", P_FETCH);
    chk("lw_cnt", instr_retired, 32'd2);

    // sw with one stall cycle
    op = 7'b0100011;
    cyc("sw_fetch", P_FETCH);
    nxt(); cyc("sw_dec", P_DEC);
    chk("sw_imm", 32'(imm_src), 32'd1);
    nxt(); cyc("sw_memadr", P_MEMADR);
    nxt(); mem_ready = 1'b0; cyc("sw_wr0", P_MEMWR);
    nxt(); mem_ready = 1'b1; cyc("sw_wr1", P_MEMWR);
    nxt(); cyc("sw_fetch2", P_FETCH);
    chk("sw_cnt", instr_retired, 32'd3);

    // beq taken then not taken
    op = 7'b1100011;
    cyc("beq1_fetch", P_FETCH);
    nxt(); cyc("beq1_dec", P_DEC);
    chk("beq_imm", 32'(imm_src), 32'd2);
    nxt(); zero = 1'b1; cyc("beq1_taken", P_BEQT);
    chk("beq1_alu", 32'(alu_control), 32'd1);
    nxt(); zero = 1'b0; cyc("beq2_fetch", P_FETCH);
    chk("beq1_cnt", instr_retired, 32'd4);
    nxt(); cyc("beq2_dec", P_DEC);
    nxt(); cyc("beq2_not", P_BEQN);
    chk("beq2_alu", 32'(alu_control), 32'd1);
    nxt(); cyc("beq2_fetch2", P_FETCH);
    chk("beq2_cnt", instr_retired, 32'd5);

    // illegal opcode
    op = 7'b0000000;
    nxt(); cyc("ill_dec", P_DECILL);
    nxt(); cyc("ill_fetch", P_FETCH);
    chk("ill_cnt", instr_retired, 32'd5);

    // jal
    op = 7'b1101111;
    #1;
    chk("jal_imm", 32'(imm_src), 32'd3);
    nxt(); cyc("jal_dec", P_DEC);
    nxt(); cyc("jal_jal", P_JAL);
    nxt(); cyc("jal_aluwb", P_ALUWB);
    nxt(); cyc("jal_fetch", P_FETCH);
    chk("jal_cnt", instr_retired, 32'd6);

    // addi with instr[30] set still adds
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    nxt(); cyc("addi_dec", P_DEC);
    nxt(); cyc("addi_execi", P_EXECI);
    chk("addi_alu", 32'(alu_control), 32'd0);
    funct3 = 3'b110; #1;
    chk("ori_alu", 32'(alu_control), 32'd3);
    funct3 = 3'b111; #1;
    chk("andi_alu", 32'(alu_control), 32'd2);
    funct3 = 3'b010; #1;
    chk("slti_alu", 32'(alu_control), 32'd5);
    nxt(); cyc("addi_aluwb", P_ALUWB);
    nxt(); cyc("addi_fetch", P_FETCH);
    chk("addi_cnt", instr_retired, 32'd7);

    // async reset in the middle of MEMWRITE
    op = 7'b0100011;
    nxt(); cyc("swr_dec", P_DEC);
    nxt(); cyc("swr_memadr", P_MEMADR);
    nxt(); mem_ready = 1'b0; cyc("swr_wr", P_MEMWR);
    #1; reset = 1'b1;
    cyc("swr_rst", P_FSTALL);
    chk("swr_rst_cnt", instr_retired, 32'd0);
    mem_ready = 1'b1;
    nxt(); cyc("swr_rst_hold", P_FSTALL);
    reset = 1'b0;
    cyc("swr_rel", P_FETCH);
    chk("swr_rel_cnt", instr_retired, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
